// File: rtl/floating_divider_if.sv
// Start/done handshake bundle for the floating-point divider; the multiplier uses the same shape.
interface floating_divider_if;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [3:0]  flags;

    modport master (output start, a, b, input busy, done, result, flags);
    modport slave  (input start, a, b, output busy, done, result, flags);
endinterface

// File: rtl/floating_divider.sv
// Iterative IEEE-754 single-precision divider, restoring division one quotient bit per clock,
// round-to-nearest-even; special operands skip the iteration.
module floating_divider (
    input  logic              clk,
    input  logic              reset,
    floating_divider_if.slave bus
);
    localparam int              QBITS    = 26;
    localparam logic signed [9:0] BIAS   = 10'sd127;
    localparam logic [4:0]      CNT_LAST = 5'(QBITS - 1);
    localparam logic [31:0]     QNAN     = 32'h7FC00000;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_UNPACK = 3'd1,
        S_DIVIDE = 3'd2,
        S_ROUND  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        a_q, a_d, b_q, b_d;
    logic [24:0]        rem_q, rem_d;
    logic [23:0]        div_q, div_d;
    logic [25:0]        quo_q, quo_d;
    logic signed [9:0]  exp_q, exp_d;
    logic [4:0]         cnt_q, cnt_d;
    logic               special_q, special_d;
    logic [31:0]        spec_res_q, spec_res_d;
    logic [3:0]         spec_flg_q, spec_flg_d;
    logic [31:0]        result_q, result_d;
    logic [3:0]         flags_q, flags_d;
    logic               busy_q, busy_d, done_q, done_d;

    logic               sign_s, a_zero_s, b_zero_s, a_inf_s, b_inf_s, a_nan_s, b_nan_s;
    logic signed [9:0]  ea_s, eb_s, exp_adj_s, exp_rnd_s;
    logic [22:0]        frac_s;
    logic               guard_s, sticky_s, inc_s;
    logic [32:0]        rnd_s;
    logic               rem_ge_s;
    logic [24:0]        diff_s;
    logic [31:0]        pack_res_s;
    logic [3:0]         pack_flg_s;

    // Operand classification; a zero exponent field (zero or denormal) counts as zero.
    always_comb begin
        sign_s   = a_q[31] ^ b_q[31];
        a_zero_s = (a_q[30:23] == 8'h00);
        b_zero_s = (b_q[30:23] == 8'h00);
        a_inf_s  = (a_q[30:23] == 8'hFF) && (a_q[22:0] == 23'd0);
        b_inf_s  = (b_q[30:23] == 8'hFF) && (b_q[22:0] == 23'd0);
        a_nan_s  = (a_q[30:23] == 8'hFF) && (a_q[22:0] != 23'd0);
        b_nan_s  = (b_q[30:23] == 8'hFF) && (b_q[22:0] != 23'd0);
        ea_s     = $signed({2'b00, a_q[30:23]});
        eb_s     = $signed({2'b00, b_q[30:23]});
        rem_ge_s = (rem_q >= {1'b0, div_q});
        diff_s   = rem_q - {1'b0, div_q};
    end

    // Normalize, round to nearest even and range-check; a fraction carry ripples into the exponent.
    always_comb begin
        if (quo_q[25]) begin
            frac_s    = quo_q[24:2];
            guard_s   = quo_q[1];
            sticky_s  = quo_q[0] | (rem_q != 25'd0);
            exp_adj_s = exp_q;
        end else begin
            frac_s    = quo_q[23:1];
            guard_s   = quo_q[0];
            sticky_s  = (rem_q != 25'd0);
            exp_adj_s = exp_q - 10'sd1;
        end
        inc_s     = guard_s & (sticky_s | frac_s[0]);
        rnd_s     = {exp_adj_s, frac_s} + {32'd0, inc_s};
        exp_rnd_s = $signed(rnd_s[32:23]);
        if (exp_rnd_s >= 10'sd255) begin
            pack_res_s = {sign_s, 8'hFF, 23'd0};
            pack_flg_s = 4'b0010;
        end else if (exp_rnd_s <= 10'sd0) begin
            pack_res_s = {sign_s, 31'd0};
            pack_flg_s = 4'b0001;
        end else begin
            pack_res_s = {sign_s, exp_rnd_s[7:0], rnd_s[22:0]};
            pack_flg_s = 4'b0000;
        end
    end

    // Control FSM next state and datapath updates.
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        rem_d      = rem_q;
        div_d      = div_q;
        quo_d      = quo_q;
        exp_d      = exp_q;
        cnt_d      = cnt_q;
        special_d  = special_q;
        spec_res_d = spec_res_q;
        spec_flg_d = spec_flg_q;
        result_d   = result_q;
        flags_d    = flags_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    flags_d = 4'h0;
                    busy_d  = 1'b1;
                    state_d = S_UNPACK;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_UNPACK: begin
                special_d  = 1'b1;
                spec_flg_d = 4'h0;
                spec_res_d = {sign_s, 31'd0};
                quo_d      = 26'd0;
                cnt_d      = 5'd0;
                if (a_nan_s || b_nan_s) begin
                    spec_res_d = QNAN;
                end else if ((a_zero_s && b_zero_s) || (a_inf_s && b_inf_s)) begin
                    spec_res_d = QNAN;
                    spec_flg_d = 4'b1000;
                end else if (a_inf_s) begin
                    spec_res_d = {sign_s, 8'hFF, 23'd0};
                end else if (b_zero_s) begin
                    spec_res_d = {sign_s, 8'hFF, 23'd0};
                    spec_flg_d = 4'b0100;
                end else if (b_inf_s || a_zero_s) begin
                    spec_res_d = {sign_s, 31'd0};
                end else begin
                    special_d = 1'b0;
                    rem_d     = {2'b01, a_q[22:0]};
                    div_d     = {1'b1, b_q[22:0]};
                    exp_d     = ea_s - eb_s + BIAS;
                end
                state_d = special_d ? S_ROUND : S_DIVIDE;
            end
            S_DIVIDE: begin
                quo_d = {quo_q[24:0], rem_ge_s};
                rem_d = rem_ge_s ? {diff_s[23:0], 1'b0} : {rem_q[23:0], 1'b0};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_ROUND;
                end else begin
                    state_d = S_DIVIDE;
                end
            end
            S_ROUND: begin
                if (special_q) begin
                    result_d = spec_res_q;
                    flags_d  = spec_flg_q;
                end else begin
                    result_d = pack_res_s;
                    flags_d  = pack_flg_s;
                end
                done_d  = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            a_q        <= 32'd0;
            b_q        <= 32'd0;
            rem_q      <= 25'd0;
            div_q      <= 24'd0;
            quo_q      <= 26'd0;
            exp_q      <= 10'sd0;
            cnt_q      <= 5'd0;
            special_q  <= 1'b0;
            spec_res_q <= 32'd0;
            spec_flg_q <= 4'h0;
            result_q   <= 32'd0;
            flags_q    <= 4'h0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            rem_q      <= rem_d;
            div_q      <= div_d;
            quo_q      <= quo_d;
            exp_q      <= exp_d;
            cnt_q      <= cnt_d;
            special_q  <= special_d;
            spec_res_q <= spec_res_d;
            spec_flg_q <= spec_flg_d;
            result_q   <= result_d;
            flags_q    <= flags_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.flags  = flags_q;
endmodule

// File: tb/tb_floating_divider.sv
// Directed-vector bench for floating_divider with hand-computed quotients, flags and latencies.
module tb_floating_divider;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    floating_divider_if bus ();

    floating_divider dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one operation and check latency, busy span, result and flags.
    task automatic do_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] er, input logic [3:0] ef, input int elat);
        int lat;
        int busy_cnt;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = av;
        bus.b     = bv;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat       = 0;
        busy_cnt  = 0;
        if (bus.busy) busy_cnt++;
        while (!bus.done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.busy) busy_cnt++;
        end
        chk_val({tag, "_lat"}, 32'(lat), 32'(elat));
        chk_val({tag, "_busy"}, 32'(busy_cnt), 32'(elat + 1));
        chk_val({tag, "_res"}, bus.result, er);
        chk_val({tag, "_flg"}, {28'd0, bus.flags}, {28'd0, ef});
        @(posedge clk);
        #1;
        chk_val({tag, "_idle"}, {30'd0, bus.busy, bus.done}, 32'd0);
    endtask

    initial begin
        int t;
        n_cmp     = 0;
        n_err     = 0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.a     = 32'd0;
        bus.b     = 32'd0;
        #12;
        chk_val("rst_out", {bus.busy, bus.done, bus.flags, 26'd0}, 32'd0);
        chk_val("rst_res", bus.result, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        do_op("6div2",   32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 28);
        do_op("1div3",   32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000, 28);
        do_op("1div1",   32'h3F800000, 32'h3F800000, 32'h3F800000, 4'b0000, 28);
        do_op("m1div0",  32'hBF800000, 32'h00000000, 32'hFF800000, 4'b0100, 2);
        do_op("0div0",   32'h00000000, 32'h00000000, 32'h7FC00000, 4'b1000, 2);
        do_op("infdinf", 32'h7F800000, 32'h7F800000, 32'h7FC00000, 4'b1000, 2);
        do_op("nan",     32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b0000, 2);
        do_op("infd2",   32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000, 2);
        do_op("2dinf",   32'h40000000, 32'h7F800000, 32'h00000000, 4'b0000, 2);
        do_op("ovf",     32'h7F7FFFFF, 32'h00800000, 32'h7F800000, 4'b0010, 28);
        do_op("unf",     32'h00800000, 32'h40000000, 32'h00000000, 4'b0001, 28);
        do_op("denorm",  32'h00000001, 32'h3F800000, 32'h00000000, 4'b0000, 2);
        do_op("neg",     32'hC0C00000, 32'h40000000, 32'hC0400000, 4'b0000, 28);

        // start held high: consecutive done pulses 30 cycles apart
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 32'h40C00000;
        bus.b     = 32'h40000000;
        t = 0;
        while (!bus.done && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk_val("b2b_first", bus.result, 32'h40400000);
        t = 0;
        do begin
            @(posedge clk);
            #1;
            t++;
        end while (!bus.done && t < 100);
        chk_val("b2b_gap", 32'(t), 32'd30);
        chk_val("b2b_res", bus.result, 32'h40400000);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_val("b2b_stop", {31'd0, bus.busy}, 32'd0);

        // second start during DIVIDE with new operands must be ignored
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 32'h41400000;
        bus.b     = 32'h40800000;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 32'h3F800000;
        bus.b     = 32'h40400000;
        @(negedge clk);
        bus.start = 1'b0;
        t = 0;
        while (!bus.done && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk_val("ign_res", bus.result, 32'h40400000);
        repeat (2) @(posedge clk);
        #1;
        chk_val("ign_idle", {31'd0, bus.busy}, 32'd0);

        // asynchronous reset mid-division
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 32'h3F800000;
        bus.b     = 32'h40400000;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (11) @(posedge clk);
        #2;
        chk_val("pre_rst_busy", {31'd0, bus.busy}, 32'd1);
        reset = 1'b1;
        #1;
        chk_val("arst_out", {bus.busy, bus.done, bus.flags, 26'd0}, 32'd0);
        chk_val("arst_res", bus.result, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        do_op("12div4", 32'h41400000, 32'h40800000, 32'h40400000, 4'b0000, 28);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
